// File: rtl/inv_rotate_pkg.sv
// Shared Keccak state geometry, rho offset table and FSM state type,
// used by both rotate directions.
package inv_rotate_pkg;

    localparam int NUM_ROW    = 5;
    localparam int NUM_COLUMN = 5;
    localparam int NUM_PAGE   = 64;
    localparam int NUM_CELLS  = 1600;

    localparam int ROW_W  = 3;
    localparam int COL_W  = 3;
    localparam int PAGE_W = 6;
    localparam int IDX_W  = 11;

    // Rho offsets r[i][j], stored row-major at entry i*5 + j.
    localparam logic [PAGE_W-1:0] RHO_OFFSET [25] = '{
        6'd0,  6'd36, 6'd3,  6'd41, 6'd18,
        6'd1,  6'd44, 6'd10, 6'd45, 6'd2,
        6'd62, 6'd6,  6'd43, 6'd15, 6'd61,
        6'd28, 6'd55, 6'd25, 6'd21, 6'd56,
        6'd27, 6'd20, 6'd39, 6'd8,  6'd14
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Rotation offset for cell (row, col).
    function automatic logic [PAGE_W-1:0] rho_offset(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
        logic [4:0] entry;
        entry = 5'(row) * 5'd5 + 5'(col);
        return RHO_OFFSET[entry];
    endfunction

    // Flat bit index of (row, col, page): page*25 + col*5 + row.
    function automatic logic [IDX_W-1:0] cell_index(input logic [ROW_W-1:0]  row,
                                                    input logic [COL_W-1:0]  col,
                                                    input logic [PAGE_W-1:0] page);
        return IDX_W'(page) * 11'd25 + IDX_W'(col) * 11'd5 + IDX_W'(row);
    endfunction

endpackage

// File: rtl/inv_rotate_counter.sv
// Wrapping up-counter used to build the row/column/page index chain.
// wrap_o is high in the cycle the counter is enabled at its last value,
// so it can enable the next counter of the chain.
module inv_rotate_counter #(
    parameter int unsigned           WIDTH   = 3,
    parameter logic [WIDTH-1:0]      MAX_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign cnt_o  = cnt_q;
    assign wrap_o = en_i && (cnt_q == MAX_VAL);

    // Next count: clear has priority, otherwise step and wrap at MAX_VAL.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == MAX_VAL) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/inv_rotate_mux3d.sv
// Three-dimensional to one-bit selector: picks state bit (row, col, page).
module inv_rotate_mux3d
    import inv_rotate_pkg::*;
(
    input  logic [NUM_CELLS-1:0] data_i,
    input  logic [ROW_W-1:0]     row_i,
    input  logic [COL_W-1:0]     col_i,
    input  logic [PAGE_W-1:0]    page_i,
    output logic                 bit_o
);

    assign bit_o = data_i[cell_index(row_i, col_i, page_i)];

endmodule

// File: rtl/inv_rotate.sv
// Inverse rho: un-rotates each 64-bit lane of a Keccak state one bit per
// cycle. Row counts fastest, then column, then page; the write of cell
// (4,4,63) closes the run and a one-cycle DONE follows.
module inv_rotate
    import inv_rotate_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CELLS-1:0] data_in,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_CELLS-1:0] data_out
);

    state_e               state_q, state_d;
    logic [NUM_CELLS-1:0] src_q;
    logic [NUM_CELLS-1:0] dout_q;

    logic                 capture;
    logic                 run;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic [PAGE_W-1:0]    page;
    logic                 row_wrap;
    logic                 col_wrap;
    logic                 page_wrap;
    logic [PAGE_W-1:0]    src_page;
    logic                 src_bit;
    logic [IDX_W-1:0]     wr_idx;

    assign run      = (state_q == ST_RUN);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign data_out = dout_q;

    // Source page is a 6-bit sum so the mod-64 wrap comes for free.
    assign src_page = page + rho_offset(row, col);
    assign wr_idx   = cell_index(row, col, page);

    inv_rotate_counter #(.WIDTH(ROW_W), .MAX_VAL(ROW_W'(NUM_ROW - 1))) u_row_cnt (
        .clk_i (clk),
        .rst_ni(rst),
        .clr_i (capture),
        .en_i  (run),
        .cnt_o (row),
        .wrap_o(row_wrap)
    );

    inv_rotate_counter #(.WIDTH(COL_W), .MAX_VAL(COL_W'(NUM_COLUMN - 1))) u_col_cnt (
        .clk_i (clk),
        .rst_ni(rst),
        .clr_i (capture),
        .en_i  (row_wrap),
        .cnt_o (col),
        .wrap_o(col_wrap)
    );

    inv_rotate_counter #(.WIDTH(PAGE_W), .MAX_VAL(PAGE_W'(NUM_PAGE - 1))) u_page_cnt (
        .clk_i (clk),
        .rst_ni(rst),
        .clr_i (capture),
        .en_i  (col_wrap),
        .cnt_o (page),
        .wrap_o(page_wrap)
    );

    inv_rotate_mux3d u_src_mux (
        .data_i(src_q),
        .row_i (row),
        .col_i (col),
        .page_i(src_page),
        .bit_o (src_bit)
    );

    // Next state: start is only honoured in IDLE; DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (page_wrap) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Source snapshot taken on the accepted start edge only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q <= '0;
        end else if (capture) begin
            src_q <= data_in;
        end
    end

    // One result bit written per RUN cycle; held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
        end else if (run) begin
            dout_q[wr_idx] <= src_bit;
        end
    end

endmodule

// File: doc/inv_rotate.md
INV_ROTATE -- requirements
Module: inv_rotate

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request to un-rotate the word on data_in.
REQ-004 SHALL have port data_in, input, `NUM_CELLS (1600), rotated Keccak state; bit index = k*25 + j*5 + i.
REQ-005 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-006 SHALL have port done, output, 1, one-cycle pulse at conversion end.
REQ-007 SHALL have port data_out, output, `NUM_CELLS, un-rotated state; same index mapping as data_in.
REQ-008 SHALL take constants NUM_ROW=5, NUM_COLUMN=5, NUM_PAGE=64 and NUM_CELLS=1600 from the shared header; no parameters.

Function
REQ-009 SHALL compute data_out[i][j][k] = data_in[i][j][(k + r[i][j]) mod 64], the inverse of the rho rotation.
REQ-010 SHALL use this offset table r[i][j], rows i=0..4, columns j=0..4:
- i=0: 0 36 3 41 18
- i=1: 1 44 10 45 2
- i=2: 62 6 43 15 61
- i=3: 28 55 25 21 56
- i=4: 27 20 39 8 14
REQ-011 SHALL compute the source page as a 6-bit sum (k + r) truncated to 6 bits, so that wrap-around mod 64 is exact.
REQ-012 SHALL have FSM states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1 at a clock edge, capture data_in into an internal source register, clear counters i, j and k, and enter RUN.
REQ-014 SHALL, in RUN, write exactly one data_out bit per cycle at address (i, j, k).
REQ-015 SHALL order the RUN writes with i fastest, then j, then k; i wraps at 5, j wraps at 5, k wraps at 64.
REQ-016 SHALL, after the write to cell (4,4,63), enter DONE; the RUN phase is exactly 1600 edges.
REQ-017 SHALL, in DONE, assert done for exactly one cycle and return to IDLE on the next edge.
REQ-018 SHALL hold busy=1 in RUN and DONE, and busy=0 in IDLE.
REQ-019 SHALL meet this latency: with start sampled at edge 0, done is high in the cycle after edge 1600.
REQ-020 SHALL ignore start while busy=1; a start during DONE does not chain into a new conversion.
REQ-021 SHALL ignore changes on data_in after the capture edge.
REQ-022 SHALL hold data_out stable from done until the next accepted start; data_out is defined only after done.
REQ-023 SHALL accept start=1 held continuously as back-to-back requests: a new capture occurs on the first IDLE edge after DONE.

Reset
REQ-024 SHALL, while rst=0, immediately force state=IDLE, counters i/j/k=0, busy=0, done=0, data_out=0 and source register=0, with no clock required.
REQ-025 SHALL, on reset mid-RUN, abort the conversion; no done is issued and the FSM waits in IDLE for a new start.

Structure
REQ-026 SHALL place NUM_ROW, NUM_COLUMN, NUM_PAGE, NUM_CELLS and the 25-entry rho offset table in the shared ISA header, for use by both rotate directions.
REQ-027 SHALL build the i/j/k index chain from the existing Counter sub-module: i is enabled by RUN, j by i overflow, k by j overflow, and k overflow ends RUN.
REQ-028 SHALL take source-bit selection from the existing MUX3Dto1, with no additional sub-modules.

Verification
REQ-029 SHALL test a single bit in a nonzero-offset cell: data_in bit 80 only (i0,j1,k3; r=36) -> after done, data_out bit 780 (k=31) only.
REQ-030 SHALL test the zero offset: data_in bit 0 only (cell (0,0), r=0) -> data_out bit 0 only.
REQ-031 SHALL test wrap-around: data_in bit 2 only (i2,j0,k0; r=62) -> data_out bit 52 (k=2) only.
REQ-032 SHALL test timing: start pulse at edge 0 -> busy high from edge 0 to edge 1601, done high only in the cycle after edge 1600, and a start at edge 500 ignored.
REQ-033 SHALL test reset: rst=0 asserted at edge 800 -> data_out=0 and busy=0 immediately, no done; a following start completes correctly.
REQ-034 SHALL test round trip: 20 random states through the forward rotate block, then inv_rotate -> output equals the original state bit-exact.
